// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract controller.
// State encoding and operation codes used by the top and the bench.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder built from gate primitives.
// This is the only arithmetic cell in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (sum, ab_x, c_in);
    and g_a0 (ab_a, a, b);
    and g_a1 (cx_a, ab_x, c_in);
    or  g_o0 (carry, ab_a, cx_a);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walked LSB first,
// one bit per clock, result presented with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PEN  = CW'(WIDTH - 2);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             msb_cin;
    logic             cell_sum;
    logic             cell_c;
    logic             accept;

    assign accept = start && (state != RUN);

    fa_cell u_cell (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c_in  (carry),
        .sum   (cell_sum),
        .carry (cell_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (cnt == LAST) ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a    <= '0;
            sh_b    <= '0;
            result  <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            sh_a    <= a;
            sh_b    <= (op == OP_SUB) ? ~b : b;
            carry   <= (op == OP_SUB) ? 1'b1 : c_in;
            result  <= '0;
            cnt     <= '0;
            msb_cin <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == RUN) begin
            result <= {cell_sum, result[WIDTH-1:1]};
            carry  <= cell_c;
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            cnt    <= cnt + CW'(1);
            // carry out of bit WIDTH-2 is the carry into the MSB
            if (cnt == PEN) begin
                msb_cin <= cell_c;
            end
            if (cnt == LAST) begin
                sum   <= {cell_sum, result[WIDTH-1:1]};
                c_out <= cell_c;
                ovf   <= msb_cin ^ cell_c;
            end
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract controller that sequences a single one-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start handshake, walks the shared cell through every bit position with a registered carry, and presents the result with a one-cycle done pulse. It is the area-minimal arithmetic path for the gate-level adder family, trading latency for a single adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  1  0 = add (a + b + c_in), 1 = subtract (a + ~b + 1, c_in ignored); sampled at accept.
- a  input  WIDTH  operand A; sampled at accept.
- b  input  WIDTH  operand B; sampled at accept.
- c_in  input  1  carry-in for add; sampled at accept.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse, result valid.
- sum  output  WIDTH  result word.
- c_out  output  1  final carry out of bit WIDTH-1 (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0, internal shift registers, bit counter and carry register cleared.
- IDLE/DONE with start=1: latch a into shift register A, b (or ~b when op=1) into shift register B, carry register ← c_in (add) or 1 (subtract); clear result register and counter; go to RUN.
- RUN, each cycle: cell inputs = A[0], B[0], carry reg; cell sum shifted into result MSB (result shifts right); carry reg ← cell carry; A, B shift right; counter increments. At counter = WIDTH-2, capture carry reg as MSB carry-in for ovf. When counter = WIDTH-1, go to DONE after this bit.
- DONE: done=1 for exactly this cycle; sum, c_out, ovf hold until the next accept. Without start, next state IDLE.
- start while busy=1: ignored, no effect on the operation in flight, not queued.
- start in the DONE cycle: accepted (back-to-back); done still pulses in that cycle.
- Arithmetic: modulo 2^WIDTH; c_out and ovf computed per standard two's-complement rules.
- Reset mid-operation: immediate abort, outputs return to reset values, no done pulse.

## Timing
- Accept at rising edge k (start=1, busy=0): busy=1 for cycles k+1 .. k+WIDTH (exactly WIDTH cycles).
- done=1 in cycle k+WIDTH+1; sum/c_out/ovf valid from the same cycle. Latency start-to-done = WIDTH+1 clocks.
- Back-to-back throughput: one result every WIDTH+1 clocks.
- busy, done, sum, c_out, ovf are all registered; no combinational path from inputs to outputs.

## Structure
- Shared package: state enum (IDLE, RUN, DONE), op encodings (OP_ADD=0, OP_SUB=1).
- One sub-module: fa_cell, a purely combinational one-bit full adder (a, b, c_in → sum, carry) built from gate primitives; instantiated exactly once.
- Counter width = clog2(WIDTH).

## Test plan
- WIDTH=8, add 0xFF + 0x01, c_in=0 → sum 0x00, c_out=1, ovf=0; busy high 8 cycles, done in cycle 9 after accept.
- Add 0x7F + 0x01, c_in=0 → sum 0x80, c_out=0, ovf=1; add 0x12 + 0x34, c_in=1 → 0x47, c_out=0, ovf=0.
- Subtract 0x05 − 0x07 → sum 0xFE, c_out=0, ovf=0; subtract 0x80 − 0x01 → 0x7F, c_out=1, ovf=1.
- start pulsed with new operands at busy cycle 3 → ignored; original result delivered unchanged, single done pulse.
- rst_n low at busy cycle 4 → busy, done, sum, c_out, ovf all 0 immediately; no done; a fresh start afterwards completes normally.
- start held high through DONE → second operation accepted, done pulses every 9 cycles, each result correct.
